// File: rtl/key_event_pkg.sv
// Shared constants, scanner state encoding and width helpers for the key event scheduler.
package key_event_pkg;

    localparam logic [1:0] EVT_RELEASE = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Register width for a value range, never narrower than one bit
    function automatic int unsigned width_of(input int unsigned count);
        return (clog2(count) == 0) ? 1 : clog2(count);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through event FIFO with registered head; a push when full is taken only
// if the head is popped in the same cycle.
module event_fifo
    import key_event_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = width_of(DEPTH);
    localparam int unsigned CNT_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        do_push  = push && (!full || do_pop);
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        // The new head is the word being written only when it lands at the next read slot
        head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            if (count_d != '0) begin
                head_q <= head_d;
            end
        end
    end

    assign head_data = head_q;
    assign empty     = !valid_q;

endmodule

// File: rtl/key_event_scheduler.sv
// Time-multiplexed key debouncer: one prescaler and one compare unit scan all keys per sample
// tick and queue press/release events. Define KEY_REPEAT_EN to add auto-repeat events.
module key_event_scheduler
    import key_event_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_MS      = 5,
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned REPEAT_DELAY   = 100,
    parameter int unsigned REPEAT_PERIOD  = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [3:0]          evt_key,
    output logic [1:0]          evt_code,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int unsigned SAMPLE_CYCLES = CLK_FREQ_HZ / 1000 * SAMPLE_MS;
    localparam int unsigned PRESC_W       = width_of(SAMPLE_CYCLES);
    localparam int unsigned CNT_W         = width_of(STABLE_SAMPLES);
    localparam int unsigned IDX_W         = width_of(NUM_KEYS);
    localparam int unsigned EVT_W         = 6;

    if (SAMPLE_CYCLES <= NUM_KEYS + 1 || NUM_KEYS < 1 || NUM_KEYS > 16) begin : gen_bad_config
        $error("key_event_scheduler: need 1..16 keys and SAMPLE_CYCLES > NUM_KEYS+1");
    end

    logic [NUM_KEYS-1:0] sync_meta_q, sync_q;
    logic [PRESC_W-1:0]  presc_q;
    logic                sample_tick;
    scan_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic                scan_active, last_idx;
    logic [NUM_KEYS-1:0] level_q;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic                cur_sync, cur_level, flip;
    logic [CNT_W-1:0]    cur_cnt, cnt_next;
    logic                push;
    logic [1:0]          push_code;
    logic [EVT_W-1:0]    fifo_head;
    logic                fifo_full, fifo_empty, pop, drop, ovf_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= keys_raw;
            sync_q      <= sync_meta_q;
        end
    end

    assign sample_tick = (presc_q == PRESC_W'(SAMPLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || sample_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sample_tick) state_d = ST_SCAN;
            ST_SCAN: if (last_idx) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_active = 1'b0;
        case (state_q)
            ST_SCAN: scan_active = 1'b1;
            default: scan_active = 1'b0;
        endcase
        last_idx = scan_active && (idx_q == IDX_W'(NUM_KEYS - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else if (scan_active) begin
            idx_q <= last_idx ? '0 : idx_q + 1'b1;
        end
    end

    // Shared compare/count unit, applied to the key selected by idx_q
    always_comb begin
        cur_sync  = sync_q[idx_q];
        cur_level = level_q[idx_q];
        cur_cnt   = cnt_q[idx_q];
        flip      = 1'b0;
        cnt_next  = '0;
        if (cur_sync != cur_level) begin
            if (cur_cnt < CNT_W'(STABLE_SAMPLES - 1)) begin
                cnt_next = cur_cnt + 1'b1;
            end else begin
                flip = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else if (scan_active) begin
            cnt_q[idx_q] <= cnt_next;
            if (flip) begin
                level_q[idx_q] <= cur_sync;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_W = width_of(REPEAT_DELAY + 1);

    logic [RPT_W-1:0] rpt_q [NUM_KEYS];
    logic [RPT_W-1:0] cur_rpt, rpt_next;
    logic             rpt_fire;

    // Counts held scans while the key stays pressed; any level change restarts it
    always_comb begin
        cur_rpt  = rpt_q[idx_q];
        rpt_next = cur_rpt;
        rpt_fire = 1'b0;
        if (flip) begin
            rpt_next = '0;
        end else if (cur_level && cur_sync) begin
            if (cur_rpt >= RPT_W'(REPEAT_DELAY - 1)) begin
                rpt_fire = 1'b1;
                rpt_next = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rpt_next = cur_rpt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                rpt_q[k] <= '0;
            end
        end else if (scan_active) begin
            rpt_q[idx_q] <= rpt_next;
        end
    end
`else
    logic unused_repeat_cfg;
    logic rpt_fire;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rpt_fire          = 1'b0;
`endif

    always_comb begin
        push      = scan_active && flip;
        push_code = cur_sync ? EVT_PRESS : EVT_RELEASE;
        if (scan_active && rpt_fire) begin
            push      = 1'b1;
            push_code = EVT_REPEAT;
        end
    end

    assign pop  = evt_valid && evt_ready;
    assign drop = push && fifo_full && !pop;

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({4'(idx_q), push_code}),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign key_level           = level_q;
    assign evt_valid           = !fifo_empty;
    assign {evt_key, evt_code} = fifo_head;
    assign ovf                 = ovf_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Randomized and directed bench for key_event_scheduler against a behavioural sampling model.
module tb_key_event_scheduler;

    localparam int NK = 4;
    localparam int SC = 10;
    localparam int SS = 3;
    localparam int FD = 4;
    localparam int RD = 5;
    localparam int RP = 2;

    logic          clk;
    logic          reset_n;
    logic [NK-1:0] keys_raw;
    logic [NK-1:0] key_level;
    logic          evt_valid;
    logic          evt_ready;
    logic [3:0]    evt_key;
    logic [1:0]    evt_code;
    logic          ovf;
    logic          ovf_clr;

    key_event_scheduler #(
        .CLK_FREQ_HZ    (10_000),
        .SAMPLE_MS      (1),
        .NUM_KEYS       (NK),
        .STABLE_SAMPLES (SS),
        .FIFO_DEPTH     (FD),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .keys_raw  (keys_raw),
        .key_level (key_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_code  (evt_code),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a key is looked at once per sample period, NK cycles after each tick
    logic [NK-1:0] m_s1, m_s2, m_level;
    int            m_cnt [NK];
`ifdef KEY_REPEAT_EN
    int            m_rpt [NK];
`endif
    int            m_n;
    logic          m_ovf;
    logic [5:0]    m_q [$];
    int            m_pop_rpts;
    int            dut_pops;
    int            dut_rpts;
    int            valid_cycles;

    function automatic logic m_push_pending();
        int k;
        if (!reset_n || m_n < SC || (m_n % SC) >= NK) return 1'b0;
        k = m_n % SC;
        return (m_s2[k] != m_level[k]) && (m_cnt[k] == SS - 1);
    endfunction

    task automatic step();
        logic       have_ev, pop;
        logic [5:0] ev;
        int         k;
        have_ev = 1'b0;
        ev      = '0;
        if (evt_valid && evt_ready) begin
            dut_pops++;
            if (evt_code == 2'b10) dut_rpts++;
        end
        if (!reset_n) begin
            m_s1    = '0;
            m_s2    = '0;
            m_level = '0;
            for (int i = 0; i < NK; i++) begin
                m_cnt[i] = 0;
`ifdef KEY_REPEAT_EN
                m_rpt[i] = 0;
`endif
            end
            m_n   = 0;
            m_ovf = 1'b0;
            m_q.delete();
        end else begin
            if (m_n >= SC && (m_n % SC) < NK) begin
                k = m_n % SC;
                if (m_s2[k] == m_level[k]) begin
                    m_cnt[k] = 0;
`ifdef KEY_REPEAT_EN
                    if (m_level[k]) begin
                        m_rpt[k]++;
                        if (m_rpt[k] == RD) begin
                            have_ev  = 1'b1;
                            ev       = {4'(k), 2'b10};
                            m_rpt[k] = RD - RP;
                        end
                    end
`endif
                end else if (m_cnt[k] < SS - 1) begin
                    m_cnt[k]++;
                end else begin
                    m_level[k] = m_s2[k];
                    m_cnt[k]   = 0;
`ifdef KEY_REPEAT_EN
                    m_rpt[k]   = 0;
`endif
                    have_ev    = 1'b1;
                    ev         = {4'(k), m_s2[k] ? 2'b01 : 2'b00};
                end
            end
            pop = (m_q.size() > 0) && evt_ready;
            if (pop) begin
                if (m_q[0][1:0] == 2'b10) m_pop_rpts++;
                void'(m_q.pop_front());
            end
            if (have_ev && m_q.size() >= FD) begin
                m_ovf = 1'b1;
            end else begin
                if (have_ev) m_q.push_back(ev);
                if (ovf_clr) m_ovf = 1'b0;
            end
            m_n++;
            m_s2 = m_s1;
            m_s1 = keys_raw;
        end
        @(posedge clk);
        #1;
        check_eq("key_level", 32'(key_level), 32'(m_level));
        check_eq("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check_eq("evt_head", 32'({evt_key, evt_code}), 32'(m_q[0]));
        check_eq("ovf", 32'(ovf), 32'(m_ovf));
        if (evt_valid) valid_cycles++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        int first_rise;
        int pops_before;
        int hold;
        n_checks   = 0;
        n_errors   = 0;
        m_pop_rpts = 0;
        dut_pops   = 0;
        dut_rpts   = 0;
        m_n        = 0;
        m_q.delete();
        reset_n    = 1'b0;
        keys_raw   = 4'hF;
        evt_ready  = 1'b0;
        ovf_clr    = 1'b0;
        #2;

        // Reset with all keys pressed
        run(3);
        check_eq("rst_evt_key", 32'(evt_key), 32'd0);
        check_eq("rst_evt_code", 32'(evt_code), 32'd0);
        check_eq("rst_evt_valid", 32'(evt_valid), 32'd0);

        // Keys stay pressed: key0 needs three samples, the first one 10 cycles after release
        reset_n    = 1'b1;
        evt_ready  = 1'b1;
        first_rise = 0;
        for (int i = 1; i <= 45; i++) begin
            step();
            if (first_rise == 0 && key_level[0]) first_rise = i;
        end
        check_eq("first_level_rise", 32'(first_rise), 32'd31);
        keys_raw = 4'h0;
        run(50);

        // Clean press of key2
        valid_cycles = 0;
        pops_before  = dut_pops;
        keys_raw     = 4'b0100;
        run(50);
        check_eq("press_valid_cycles", 32'(valid_cycles), 32'd1);
        check_eq("press_level2", 32'(key_level[2]), 32'd1);
        keys_raw = 4'h0;
        run(50);
        check_eq("press_release_pops", 32'(dut_pops - pops_before), 32'd2);

        // Bounce on key1
        pops_before = dut_pops;
        for (int i = 0; i < 100; i++) begin
            keys_raw[1] = ((i / 15) % 2) == 0;
            step();
        end
        keys_raw = 4'h0;
        run(50);
        check_eq("bounce_pops", 32'(dut_pops - pops_before), 32'd0);
        check_eq("bounce_level1", 32'(key_level[1]), 32'd0);

        // Backpressure: eight events into a four-entry queue
        evt_ready = 1'b0;
        keys_raw  = 4'hF;
        run(50);
        keys_raw = 4'h0;
        run(50);
        check_eq("bp_ovf_set", 32'(ovf), 32'd1);
        pops_before = dut_pops;
        evt_ready   = 1'b1;
        ovf_clr     = 1'b1;
        step();
        ovf_clr = 1'b0;
        run(20);
        check_eq("bp_drained", 32'(dut_pops - pops_before), 32'd4);
        check_eq("bp_ovf_clr", 32'(ovf), 32'd0);

        // Full queue, pop only on the cycles that push
        evt_ready = 1'b0;
        keys_raw  = 4'hF;
        run(50);
        check_eq("full_valid", 32'(evt_valid), 32'd1);
        keys_raw = 4'h0;
        for (int i = 0; i < 60; i++) begin
            evt_ready = m_push_pending();
            step();
        end
        check_eq("full_pop_ovf", 32'(ovf), 32'd0);
        evt_ready = 1'b1;
        run(20);

        // Long hold of key0 (repeats only when KEY_REPEAT_EN is defined)
        dut_rpts   = 0;
        m_pop_rpts = 0;
        keys_raw   = 4'b0001;
        run(200);
        keys_raw = 4'h0;
        run(60);
        check_eq("repeat_count", 32'(dut_rpts), 32'(m_pop_rpts));
`ifdef KEY_REPEAT_EN
        check_eq("repeat_seen", 32'(dut_rpts != 0), 32'd1);
`else
        check_eq("repeat_seen", 32'(dut_rpts != 0), 32'd0);
`endif

        // Random keys, backpressure and clears, with one reset landing mid-scan
        for (int it = 0; it < 120; it++) begin
            keys_raw = 4'($urandom_range(0, 15));
            hold     = $urandom_range(5, 60);
            for (int c = 0; c < hold; c++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                ovf_clr   = ($urandom_range(0, 7) == 0);
                step();
            end
            if (it == 60) begin
                for (int c = 0; c < 40 && !(m_n >= SC && (m_n % SC) == 2); c++) step();
                reset_n = 1'b0;
                run(2);
                reset_n = 1'b1;
            end
        end
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        keys_raw  = 4'h0;
        run(80);
        check_eq("final_idle", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
